// File: rtl/texture_request_scheduler_if.sv
// Core request/return and texture/RGB FIFO signals of the texture request scheduler.
// The master modport is the scheduler side; the slave modport is the cores/FIFO side.
interface texture_request_scheduler_if #(
  parameter int NUM_CORES = 4,
  parameter int OUT_W     = 5
);
  logic [NUM_CORES-1:0]    core_req;
  logic [NUM_CORES*24-1:0] core_addr;
  logic [NUM_CORES-1:0]    core_ack;
  logic [NUM_CORES-1:0]    core_rvalid;
  logic [31:0]             core_rdata;
  logic                    FF_texture_almostfull;
  logic                    FF_texture_writerequest;
  logic [31:0]             FF_texture_data;
  logic                    FF_rgb_empty;
  logic                    FF_rgb_readrequest;
  logic [31:0]             FF_rgb_q;
  logic [OUT_W-1:0]        outstanding;
  logic                    busy;
  logic                    err_sticky;

  modport master (
    input  core_req, core_addr, FF_texture_almostfull, FF_rgb_empty, FF_rgb_q,
    output core_ack, core_rvalid, core_rdata, FF_texture_writerequest, FF_texture_data,
           FF_rgb_readrequest, outstanding, busy, err_sticky
  );

  modport slave (
    output core_req, core_addr, FF_texture_almostfull, FF_rgb_empty, FF_rgb_q,
    input  core_ack, core_rvalid, core_rdata, FF_texture_writerequest, FF_texture_data,
           FF_rgb_readrequest, outstanding, busy, err_sticky
  );
endinterface

// File: rtl/texture_request_scheduler.sv
// Round-robin arbiter feeding the texture FIFO, plus a return FSM that drains
// {data, core_id} pairs from the RGB FIFO and routes the data back to its core.
module texture_request_scheduler #(
  parameter int NUM_CORES       = 4,
  parameter int MAX_OUTSTANDING = 16,
  parameter int OUT_W           = 5
) (
  input logic                        iClk,
  input logic                        iRstn,
  texture_request_scheduler_if.master bus
);
  localparam int IDW = $clog2(NUM_CORES);

  typedef enum logic [2:0] {R_IDLE, R_DATA, R_WAIT_ID, R_ID, R_DELIVER} rstate_e;

  rstate_e                       state_q, state_d;
  logic [IDW-1:0]                rr_ptr_q, rr_ptr_d;
  logic [31:0]                   data_q, data_d;
  logic [7:0]                    id_q, id_d;
  logic [NUM_CORES-1:0]          rvalid_q, rvalid_d;
  logic [31:0]                   rdata_q, rdata_d;
  logic [OUT_W-1:0]              out_q, out_d;
  logic                          err_q, err_d;

  logic [NUM_CORES-1:0][23:0]    addr_arr;
  logic                          issue_ok, grant_vld, issue;
  logic [IDW-1:0]                grant;
  logic                          rdreq, deliver, bad_id;

  assign addr_arr = bus.core_addr;

  // Rotating priority search starting at rr_ptr; first requester wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant     = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!grant_vld && bus.core_req[idx]) begin
        grant_vld = 1'b1;
        grant     = IDW'(idx);
      end
    end
  end

  // Reset gating keeps the combinational issue/read strobes quiet while held in reset.
  assign issue_ok = iRstn && !bus.FF_texture_almostfull &&
                    (out_q < OUT_W'(MAX_OUTSTANDING));
  assign issue    = issue_ok && grant_vld;

  assign bus.core_ack                = issue ? (NUM_CORES'(1) << grant) : '0;
  assign bus.FF_texture_writerequest = issue;
  assign bus.FF_texture_data         = issue ? {8'(grant), addr_arr[grant]} : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue) rr_ptr_d = (grant == IDW'(NUM_CORES - 1)) ? '0 : grant + 1'b1;
  end

  // Return path: the FIFO is in normal mode, so q is valid the cycle after the strobe.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    id_d     = id_q;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    rdreq    = 1'b0;
    deliver  = 1'b0;
    bad_id   = 1'b0;
    case (state_q)
      R_IDLE: if (!bus.FF_rgb_empty) begin
        rdreq   = 1'b1;
        state_d = R_DATA;
      end
      R_DATA: begin
        data_d = bus.FF_rgb_q;
        if (!bus.FF_rgb_empty) begin
          rdreq   = 1'b1;
          state_d = R_ID;
        end else begin
          state_d = R_WAIT_ID;
        end
      end
      R_WAIT_ID: if (!bus.FF_rgb_empty) begin
        rdreq   = 1'b1;
        state_d = R_ID;
      end
      R_ID: begin
        id_d    = bus.FF_rgb_q[7:0];
        state_d = R_DELIVER;
      end
      R_DELIVER: begin
        deliver = 1'b1;
        if (id_q < 8'(NUM_CORES)) begin
          rvalid_d[id_q[IDW-1:0]] = 1'b1;
          rdata_d                 = data_q;
        end else begin
          bad_id = 1'b1;
        end
        state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

  // A delivery with nothing outstanding is a protocol error; the count saturates.
  always_comb begin
    out_d = out_q;
    err_d = err_q | bad_id;
    if (issue && !deliver) begin
      out_d = out_q + 1'b1;
    end else if (!issue && deliver) begin
      if (out_q == '0) err_d = 1'b1;
      else             out_d = out_q - 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state_q  <= R_IDLE;
      rr_ptr_q <= '0;
      data_q   <= '0;
      id_q     <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      id_q     <= id_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      out_q    <= out_d;
      err_q    <= err_d;
    end
  end

  assign bus.FF_rgb_readrequest = rdreq && iRstn;
  assign bus.core_rvalid        = rvalid_q;
  assign bus.core_rdata         = rdata_q;
  assign bus.outstanding        = out_q;
  assign bus.busy               = (out_q != '0) || (state_q != R_IDLE);
  assign bus.err_sticky         = err_q;
endmodule
